uart_tx_feeder: RTL

Transmit-side buffer and sequencer directly upstream of the UART transmitter. It accepts bytes from the host/core logic into a FIFO of depth 2^ADDR_W. It presents each byte on tx_din with a single-cycle tx_start pulse, then waits for the transmitter's tx_done_tick before issuing the next byte. Its outputs tx_start and tx_din connect directly to the transmitter's tx_start and din; its tx_done_tick input is driven by the transmitter's tx_done_tick.

---
 rtl/uart_tx_feeder_pkg.sv | 17 +
 rtl/uart_tx_feeder_fifo_sync.sv | 104 ++++++++++
 rtl/uart_tx_feeder.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder.
// Contents:
//   DbitDefault  - default data word width (must match the transmitter's din width)
//   AddrWDefault - default FIFO address width (depth = 2**AddrWDefault)
//   state_e      - one-hot sequencer states
package uart_tx_feeder_pkg;

    localparam int unsigned DbitDefault  = 8;
    localparam int unsigned AddrWDefault = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StStart = 3'b010,
        StWait  = 3'b100
    } state_e;

endpackage

// File: rtl/uart_tx_feeder_fifo_sync.sv
// Synchronous FIFO with occupancy count and a sticky overflow flag.
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   wr_en, wr_data    - write strobe and data; writes while full are dropped
//   ovf_clr           - clears overflow unless a write is dropped in the same cycle
//   pop               - read strobe; rd_data is the head entry (combinational)
//   full, empty       - decoded from the registered count
//   count             - number of stored entries (0 .. 2**ADDR_W)
//   overflow          - sticky: at least one write was dropped
module uart_tx_feeder_fifo_sync
    import uart_tx_feeder_pkg::*;
#(
    parameter int unsigned DBIT   = DbitDefault,
    parameter int unsigned ADDR_W = AddrWDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              ovf_clr,
    input  logic              pop,
    output logic [DBIT-1:0]   rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CountFull = (ADDR_W + 1)'(Depth);
    localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

    logic [DBIT-1:0]   mem_q [Depth];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic wr_ok;
    logic pop_ok;
    logic wr_drop;

    assign full  = (count_q == CountFull);
    assign empty = (count_q == '0);

    assign wr_ok   = wr_en && !full;
    // A pop does not make room for a write in the same cycle: full is registered.
    assign wr_drop = wr_en && full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        case ({wr_ok, pop_ok})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase

        // Set wins over clear.
        if (wr_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit-side buffer and sequencer feeding a UART transmitter.
// Bytes are queued in a FIFO; each byte is loaded into tx_din and announced with a
// single-cycle tx_start, and the next byte waits for the transmitter's tx_done_tick.
// Ports:
//   clk, reset     - clock and asynchronous active-high reset
//   wr_en, wr_data - host write strobe and byte
//   ovf_clr        - clear the sticky overflow flag
//   tx_done_tick   - end-of-stop-bit pulse from the transmitter
//   tx_start       - one-cycle start pulse to the transmitter
//   tx_din         - registered byte, stable for the whole transmission
//   full, empty    - FIFO status
//   count          - FIFO occupancy
//   overflow       - sticky dropped-write flag
//   busy           - sequencer is not idle
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int unsigned DBIT   = DbitDefault,
    parameter int unsigned ADDR_W = AddrWDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              ovf_clr,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy
);

    state_e          state_q, state_d;
    logic [DBIT-1:0] tx_din_q, tx_din_d;
    logic            pop;
    logic [DBIT-1:0] fifo_rd_data;

    uart_tx_feeder_fifo_sync #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .pop      (pop),
        .rd_data  (fifo_rd_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d  = state_q;
        tx_din_d = tx_din_q;
        pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop      = 1'b1;
                    tx_din_d = fifo_rd_data;
                    state_d  = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done_tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            tx_din_q <= '0;
        end else begin
            state_q  <= state_d;
            tx_din_q <= tx_din_d;
        end
    end

    // Moore outputs straight from the one-hot state register.
    assign tx_start = (state_q == StStart);
    assign busy     = (state_q != StIdle);
    assign tx_din   = tx_din_q;

endmodule
